// File: rtl/hex_arb_pkg.sv
// rtl/hex_arb_pkg.sv - shared types and segment constants for the hex display arbiter
package hex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Active-high {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/hex_digit_enc.sv
// rtl/hex_digit_enc.sv - one hex digit to an active-low {dp,g,f,e,d,c,b,a} byte
module hex_digit_enc
    import hex_arb_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg_n
);

    always_comb begin
        if (blank) begin
            seg_n = SEG_OFF;
        end else begin
            seg_n = ~{dp, SEG_LUT[nibble]};
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin min-hold owner of the 8-digit display
// Optional leading-zero blanking under HEX_ARB_LZ_BLANK_EN.
module hex_display_arbiter
    import hex_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [1:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [7:0]  dp0,
    input  logic [7:0]  dp1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [31:0] hex0_3_export,
    output logic [31:0] hex4_7_export
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             rr_q, rr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [63:0]      hex_q, hex_d;

    logic [31:0]      owner_val;
    logic [7:0]       owner_dp;
    logic [7:0]       blank;
    logic [63:0]      enc_word;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rr_d       = rr_q;
        case (state_q)
            IDLE: begin
                if (req == 2'b11)  state_d = rr_q ? OWN1 : OWN0;
                else if (req[0])   state_d = OWN0;
                else if (req[1])   state_d = OWN1;
            end
            OWN0: begin
                if (!req[0])                             state_d = req[1] ? OWN1 : IDLE;
                else if (hold_cnt_q == HOLD_MAX && req[1]) state_d = OWN1;
                else if (hold_cnt_q != HOLD_MAX)         hold_cnt_d = hold_cnt_q + 1'b1;
            end
            OWN1: begin
                if (!req[1])                             state_d = req[0] ? OWN0 : IDLE;
                else if (hold_cnt_q == HOLD_MAX && req[0]) state_d = OWN0;
                else if (hold_cnt_q != HOLD_MAX)         hold_cnt_d = hold_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A fresh owner restarts its hold window and hands priority to the other side.
        if (state_d != state_q && state_d != IDLE) begin
            hold_cnt_d = '0;
            rr_d       = (state_d == OWN0);
        end
        if (state_d == IDLE) hold_cnt_d = '0;
        gnt_d  = {state_d == OWN1, state_d == OWN0};
        busy_d = (state_d != IDLE);
    end

    assign owner_val = (state_q == OWN1) ? data1 : data0;
    assign owner_dp  = (state_q == OWN1) ? dp1   : dp0;

`ifdef HEX_ARB_LZ_BLANK_EN
    logic lz_run;
    always_comb begin
        lz_run = 1'b1;
        blank  = '0;
        for (int i = 7; i >= 1; i--) begin
            lz_run   = lz_run & (owner_val[4*i +: 4] == 4'h0) & ~owner_dp[i];
            blank[i] = lz_run;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < 8; g++) begin : g_dig
        hex_digit_enc u_enc (
            .nibble (owner_val[4*g +: 4]),
            .dp     (owner_dp[g]),
            .blank  (blank[g]),
            .seg_n  (enc_word[8*g +: 8])
        );
    end

    always_comb begin
        hex_d = {8{SEG_OFF}};
        if (state_q != IDLE) hex_d = enc_word;
    end

    always_ff @(posedge clk_clk or negedge reset_reset) begin
        if (!reset_reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            rr_q       <= 1'b0;
            gnt_q      <= 2'b00;
            busy_q     <= 1'b0;
            hex_q      <= {8{SEG_OFF}};
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            hex_q      <= hex_d;
        end
    end

    assign gnt           = gnt_q;
    assign busy          = busy_q;
    assign hex0_3_export = hex_q[31:0];
    assign hex4_7_export = hex_q[63:32];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - scoreboard bench for hex_display_arbiter
module tb_hex_display_arbiter;

    localparam int HOLD = 4;
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [1:0]  req;
    logic [31:0] data0, data1;
    logic [7:0]  dp0, dp1;
    logic [1:0]  gnt;
    logic        busy;
    logic [31:0] hex0_3_export, hex4_7_export;

    hex_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .req           (req),
        .data0         (data0),
        .data1         (data1),
        .dp0           (dp0),
        .dp1           (dp1),
        .gnt           (gnt),
        .busy          (busy),
        .hex0_3_export (hex0_3_export),
        .hex4_7_export (hex4_7_export)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        busy;
        logic [63:0] hex;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_hex(input logic [31:0] v, input logic [7:0] dp);
        logic [63:0] r;
        int lz;
        int nib;
        lz = 0;
`ifdef HEX_ARB_LZ_BLANK_EN
        while (lz < 7 && ((v >> (4 * (7 - lz))) & 32'hF) == 0 && !dp[7 - lz]) lz++;
`endif
        for (int d = 0; d < 8; d++) begin
            nib = int'((v >> (4 * d)) & 32'hF);
            if (d >= 8 - lz) r[8*d +: 8] = 8'hFF;
            else             r[8*d +: 8] = ~{dp[d], SEG[nib]};
        end
        return r;
    endfunction

    // Behavioural model: owner is -1 (nobody), 0 or 1; held counts cycles of the current tenure.
    int owner = -1;
    int held  = 0;
    int fav   = 0;

    always @(posedge clk_clk or negedge reset_reset) begin
        exp_t e;
        int   other, prev;
        if (!reset_reset) begin
            owner = -1;
            held  = 0;
            fav   = 0;
            sb_q.delete();
        end else begin
            e.hex = (owner < 0) ? {64{1'b1}}
                  : (owner == 1) ? model_hex(data1, dp1) : model_hex(data0, dp0);
            prev = owner;
            if (owner < 0) begin
                if (req == 2'b11) owner = fav;
                else if (req[0])  owner = 0;
                else if (req[1])  owner = 1;
            end else begin
                other = 1 - owner;
                if (!req[owner])                            owner = req[other] ? other : -1;
                else if (held >= HOLD - 1 && req[other])    owner = other;
                else                                        held = (held + 1 > HOLD - 1) ? HOLD - 1 : held + 1;
            end
            if (owner != prev && owner >= 0) begin
                held = 0;
                fav  = 1 - owner;
            end
            e.gnt  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            e.busy = (owner >= 0);
            sb_q.push_back(e);
        end
    end

    always @(negedge clk_clk) begin
        exp_t e;
        if (!reset_reset) begin
            check("rst_gnt", 64'(gnt), 64'(2'b00));
            check("rst_busy", 64'(busy), 64'(1'b0));
            check("rst_hex", {hex4_7_export, hex0_3_export}, {64{1'b1}});
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_gnt", 64'(gnt), 64'(e.gnt));
            check("sb_busy", 64'(busy), 64'(e.busy));
            check("sb_hex", {hex4_7_export, hex0_3_export}, e.hex);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    initial begin
        reset_reset = 1'b0;
        req = 2'b00; data0 = '0; data1 = '0; dp0 = '0; dp1 = '0;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset = 1'b1;
        cyc(3);

        req = 2'b01; data0 = 32'h0000_0000; dp0 = 8'h00;
        cyc(3);
        check("single_gnt", 64'(gnt), 64'(2'b01));
`ifndef HEX_ARB_LZ_BLANK_EN
        check("zero_lo", 64'(hex0_3_export), 64'(32'hC0C0C0C0));
        check("zero_hi", 64'(hex4_7_export), 64'(32'hC0C0C0C0));
`endif
        data0 = 32'h8888_8888;
        cyc(1);
        check("eight_lo", 64'(hex0_3_export), 64'(32'h80808080));
        check("eight_hi", 64'(hex4_7_export), 64'(32'h80808080));
        data0 = 32'h0000_0105;
        cyc(1);
`ifdef HEX_ARB_LZ_BLANK_EN
        check("lz_hi", 64'(hex4_7_export), 64'(32'hFFFFFFFF));
        check("lz_lo", 64'(hex0_3_export), 64'(32'hFFF9C092));
`else
        check("nolz_hi", 64'(hex4_7_export), 64'(32'hC0C0C0C0));
        check("nolz_lo", 64'(hex0_3_export), 64'(32'hC0F9C092));
`endif
        dp0 = 8'h80;
        cyc(1);
        check("dp7_hi", 64'(hex4_7_export), 64'(32'h40C0C0C0));
        check("dp7_lo", 64'(hex0_3_export), 64'(32'hC0F9C092));
        dp0 = 8'h00;

        req = 2'b11;
        cyc(20);

        req = 2'b00;
        cyc(2);
        req = 2'b01;
        cyc(2);
        req = 2'b10;
        cyc(1);
        check("release_gnt", 64'(gnt), 64'(2'b10));
        req = 2'b00;
        cyc(1);
        check("idle_gnt", 64'(gnt), 64'(2'b00));
        check("idle_busy", 64'(busy), 64'(1'b0));
        cyc(1);
        check("idle_hex", {hex4_7_export, hex0_3_export}, {64{1'b1}});

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) req = 2'($urandom);
            data0 = $urandom >> $urandom_range(0, 31);
            data1 = $urandom >> $urandom_range(0, 31);
            dp0   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            dp1   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cyc(1);
        end

        req = 2'b10; data1 = 32'h1234_5678;
        cyc(3);
        #2 reset_reset = 1'b0;
        #1;
        check("async_gnt", 64'(gnt), 64'(2'b00));
        check("async_busy", 64'(busy), 64'(1'b0));
        check("async_hex", {hex4_7_export, hex0_3_export}, {64{1'b1}});
        req = 2'b11;
        @(posedge clk_clk);
        #1 reset_reset = 1'b1;
        cyc(1);
        check("post_rst_gnt", 64'(gnt), 64'(2'b01));
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares the eight-digit seven-segment display between two requesters: Nios PIO software path (req 0) and a hardware status source (req 1).
- Arbitrates ownership with a minimum-hold round-robin policy.
- Encodes the owner's 32-bit hex value into active-low segment words for hex0_3_export and hex4_7_export.
- Sits between the Qsys system outputs and the board display pins.

Parameters:
HOLD_CYCLES, 5000000, minimum grant duration in clocks (100 ms at 50 MHz); legal range >= 1
CNT_W, $clog2(HOLD_CYCLES+1), hold counter width (derived, not overridden)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous reset, active-low
req  in  2  request per requester; level, held while display wanted
data0  in  32  requester 0 value, nibble n -> digit n
data1  in  32  requester 1 value
dp0  in  8  requester 0 decimal points, bit n -> digit n, 1 = lit
dp1  in  8  requester 1 decimal points
gnt  out  2  one-hot grant, registered
busy  out  1  any grant active
hex0_3_export  out  32  digits 3..0, byte n = digit n, bits {dp,g,f,e,d,c,b,a}, active-low
hex4_7_export  out  32  digits 7..4, same format

Behaviour:
- Reset: async assert on reset_reset=0; sync release on clock edge.
  - Reset values: gnt=2'b00, busy=0, hex outputs 32'hFFFFFFFF (all segments off).
  - Reset values: hold_cnt=0, rr pointer=0 (requester 0 favoured).
- Reset mid-grant: outputs return to reset values immediately, with no wait for the clock.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: req==2'b01 -> OWN0; req==2'b10 -> OWN1; req==2'b11 -> requester named by rr pointer.
  - OWNn: hold_cnt increments each cycle and saturates at HOLD_CYCLES-1.
  - OWNn, owner drops req: next state is other owner if it requests, else IDLE. Applies regardless of hold_cnt.
  - OWNn, hold_cnt==HOLD_CYCLES-1 and other requester asserted: switch to other owner.
  - OWNn, hold expired and other not requesting: owner keeps the grant.
  - Every state change into OWNx clears hold_cnt to 0 and sets rr pointer to the non-owner.
- HOLD_CYCLES=1 with both requesting: grant alternates every cycle.
- gnt latency: asserted on the cycle after req is sampled. Exactly one gnt bit high, or none.
- Display datapath:
  - Segment outputs registered, one cycle after gnt/state register; data change while owned -> outputs change one clock later.
  - IDLE: outputs 32'hFFFFFFFF.
  - Segment table for 0-F, active-high before inversion: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - Byte output = ~{dp, seg[6:0]}.
- Requester data is not latched: owner must hold data stable or accept live updates.

Optional Feature:
- Macro HEX_ARB_LZ_BLANK_EN.
- Defined: leading-zero digits of the owner value are blanked (byte 8'hFF), scanning from digit 7 down.
  - Digit 0 is never blanked.
  - A digit whose dp bit is set is never blanked, and it terminates the leading run.
- Undefined: all eight digits always shown.

Decomposition:
- Shared package hex_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1}
  - 16-entry SEG_LUT constant
  - SEG_OFF = 8'hFF
- Sub-module hex_digit_enc: combinational nibble + dp + blank -> active-low byte.
  - Instantiated 8 times.
  - Output registers stay in the top-level module.

Test Plan:
- Reset: hold reset_reset=0 -> gnt=0, busy=0, both hex outputs 32'hFFFFFFFF. Release with req=0 -> outputs unchanged.
- Single owner: req=01, data0=32'h00000000, dp0=0 -> gnt=01 next cycle, hex0_3=hex4_7=32'hC0C0C0C0 one cycle later. data0=32'h88888888 -> 32'h80808080 after 1 clock.
- Round-robin (HOLD_CYCLES=4): req=11 from IDLE -> gnt=01 for 4 cycles, then 10 for 4 cycles, then 01.
- Owner release: HOLD_CYCLES=4, OWN0, req drops to 10 at hold_cnt=1 -> gnt=10 next cycle. Then req=00 -> gnt=00, busy=0, hex=32'hFFFFFFFF one cycle later.
- Async reset mid-grant: assert reset_reset between clock edges during OWN1 -> gnt=00, outputs 32'hFFFFFFFF before the next edge. After release with req=11 -> requester 0 granted first.
- HEX_ARB_LZ_BLANK_EN defined: data0=32'h00000105, dp0=0 -> hex4_7=32'hFFFFFFFF, hex0_3=32'hFFF9C092. With dp0=8'h80 -> digit 7 shows 0x40 and no digits are blanked.
